// File: rtl/vga_timing_gen.sv
// VGA raster timing source: pixel-rate divider, h/v counters, and a registered
// output stage that keeps sync, blank and renderer colour aligned at the DAC.
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r_in,
    input  logic [7:0] g_in,
    input  logic [7:0] b_in,
    output logic [9:0] x_cnt,
    output logic [9:0] y_cnt,
    output logic       active,
    output logic       pix_tick,
    output logic       frame_start,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync end equal to 1024 still compares correctly
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic       w_tick;
    logic [9:0] r_h, r_v;
    logic       w_h_wrap, w_active, w_hs_n, w_vs_n;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign w_tick = 1'b1;
        end else begin : g_div
            localparam int            DW       = $clog2(CLK_DIV);
            localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
            logic [DW-1:0] r_div;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                    r_div <= '0;
                else if (r_div == DIV_LAST) r_div <= '0;
                else                        r_div <= r_div + DW'(1);
            end
            assign w_tick = (r_div == DIV_LAST);
        end
    endgenerate

    assign w_h_wrap = (r_h == H_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (w_h_wrap) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
            end else begin
                r_h <= r_h + 10'd1;
            end
        end
    end

    assign w_active = ({1'b0, r_h} < H_ACT) && ({1'b0, r_v} < V_ACT);
    assign w_hs_n   = !(({1'b0, r_h} >= H_SS) && ({1'b0, r_h} < H_SE));
    assign w_vs_n   = !(({1'b0, r_v} >= V_SS) && ({1'b0, r_v} < V_SE));

    // Colour and sync are captured on the same tick, so the DAC sees them together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else if (w_tick) begin
            vga_hs      <= w_hs_n;
            vga_vs      <= w_vs_n;
            vga_blank_n <= w_active;
            vga_r       <= w_active ? r_in : 8'd0;
            vga_g       <= w_active ? g_in : 8'd0;
            vga_b       <= w_active ? b_in : 8'd0;
        end
    end

    assign x_cnt       = r_h;
    assign y_cnt       = r_v;
    assign active      = w_active;
    assign pix_tick    = w_tick;
    assign frame_start = w_tick && (r_h == 10'd0) && (r_v == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full 640x480 timing (CLK_DIV=2) for line-level checks, plus a
// shrunken raster (CLK_DIV=1) so whole frames and mid-vsync reset fit a short run.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Unit A: default 640x480 raster, CLK_DIV=2
  logic       rst_a;
  logic [9:0] xa, ya;
  logic       act_a, tick_a, fs_a, hs_a, vs_a, bn_a;
  logic [7:0] ra, ga, ba, ria, gia, bia;
  assign ria = xa[7:0];
  assign gia = ya[7:0];
  assign bia = 8'hFF;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst_a), .r_in(ria), .g_in(gia), .b_in(bia),
    .x_cnt(xa), .y_cnt(ya), .active(act_a), .pix_tick(tick_a), .frame_start(fs_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(bn_a), .vga_r(ra), .vga_g(ga), .vga_b(ba)
  );

  // Unit B: 16x6 visible, H total 24, V total 11, CLK_DIV=1
  logic       rst_b;
  logic [9:0] xb, yb;
  logic       act_b, tick_b, fs_b, hs_b, vs_b, bn_b;
  logic [7:0] rb, gb, bb, rib, gib, bib;
  assign rib = xb[7:0];
  assign gib = yb[7:0];
  assign bib = 8'hFF;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u_b (
    .clk(clk), .rst(rst_b), .r_in(rib), .g_in(gib), .b_in(bib),
    .x_cnt(xb), .y_cnt(yb), .active(act_b), .pix_tick(tick_b), .frame_start(fs_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bn_b), .vga_r(rb), .vga_g(gb), .vga_b(bb)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_tick, hs_fall, hs_rise, line1;
    int fs1, fs2, vs_fall, vs_rise, bhs_fall, bhs_rise, tick_miss;
    logic prev_hs, prev_vs, seen640, seen641, seen_c, seen_blk;
    logic [9:0] px, py;

    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_rst_x", xa, 0);
    chk("a_rst_y", ya, 0);
    chk("a_rst_hs", hs_a, 1);
    chk("a_rst_vs", vs_a, 1);
    chk("a_rst_blank_n", bn_a, 0);
    chk("a_rst_rgb", {ra, ga, ba}, 0);
    chk("a_rst_tick", tick_a, 0);
    chk("b_rst_tick_held", tick_b, 1);

    // ---- Unit A: one full line after reset release ----
    rst_a = 1'b0;
    n_tick = 0; hs_fall = -1; hs_rise = -1; line1 = -1;
    prev_hs = 1'b1; seen640 = 1'b0; seen641 = 1'b0;
    for (int c = 1; c <= 1700; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("a_first_fs", fs_a, 1);
        chk("a_first_x", xa, 0);
        chk("a_hold_blank_n", bn_a, 0);
        chk("a_hold_b", ba, 0);
      end
      if (c == 2) begin
        chk("a_x_after_tick", xa, 1);
        chk("a_pix0_blank_n", bn_a, 1);
        chk("a_pix0_b", ba, 8'hFF);
        chk("a_fs_drop", fs_a, 0);
      end
      if (tick_a) n_tick++;
      // registered sync lags the counter: pixel 656 is on the pins while x_cnt=657
      if (!hs_a && prev_hs && hs_fall < 0) begin
        hs_fall = c;
        chk("a_hs_fall_x", xa, 657);
      end
      if (hs_a && !prev_hs && hs_rise < 0) begin
        hs_rise = c;
        chk("a_hs_rise_x", xa, 753);
      end
      prev_hs = hs_a;
      if (tick_a && xa == 0 && ya == 1 && line1 < 0) line1 = c;
      if (xa == 640 && !seen640) begin
        seen640 = 1'b1;
        chk("a_px639_r", ra, 8'h7F);
        chk("a_px639_g", ga, 8'h00);
        chk("a_px639_b", ba, 8'hFF);
        chk("a_px639_blank_n", bn_a, 1);
      end
      if (xa == 641 && !seen641) begin
        seen641 = 1'b1;
        chk("a_px640_rgb", {ra, ga, ba}, 0);
        chk("a_px640_blank_n", bn_a, 0);
      end
    end
    chk("a_tick_count", n_tick, 850);
    chk("a_hs_low_clks", hs_rise - hs_fall, 192);
    chk("a_line_period_clk", line1, 1601);
    chk("a_seen640", seen640, 1);
    chk("a_vs_idle", vs_a, 1);

    // ---- Unit B: two frames with CLK_DIV=1 ----
    rst_b = 1'b0;
    #1;
    chk("b_fs_release", fs_b, 1);
    fs1 = -1; fs2 = -1; vs_fall = -1; vs_rise = -1; bhs_fall = -1; bhs_rise = -1;
    tick_miss = 0; prev_hs = 1'b1; prev_vs = 1'b1; seen_c = 1'b0; seen_blk = 1'b0;
    px = 10'd0; py = 10'd0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (!tick_b) tick_miss++;
      if (fs_b) begin
        if (fs1 < 0) begin
          fs1 = c;
          chk("b_wrap_prev_x", px, 23);
          chk("b_wrap_prev_y", py, 10);
          chk("b_wrap_y", yb, 0);
        end else if (fs2 < 0) fs2 = c;
      end
      if (!vs_b && prev_vs && vs_fall < 0) begin
        vs_fall = c;
        chk("b_vs_fall_y", yb, 7);
        chk("b_vs_fall_x", xb, 1);
      end
      if (vs_b && !prev_vs && vs_rise < 0) vs_rise = c;
      if (!hs_b && prev_hs && bhs_fall < 0) begin
        bhs_fall = c;
        chk("b_hs_fall_x", xb, 19);
      end
      if (hs_b && !prev_hs && bhs_rise < 0) bhs_rise = c;
      if (xb == 16 && yb == 5 && !seen_c) begin
        seen_c = 1'b1;
        chk("b_px15_5_rg", {rb, gb}, 16'h0F05);
        chk("b_px15_5_blank_n", bn_b, 1);
      end
      if (xb == 17 && yb == 5 && !seen_blk) begin
        seen_blk = 1'b1;
        chk("b_px16_5_rgb", {rb, gb, bb}, 0);
      end
      prev_hs = hs_b;
      prev_vs = vs_b;
      px = xb;
      py = yb;
    end
    chk("b_tick_miss", tick_miss, 0);
    chk("b_first_fs_clk", fs1, 264);
    chk("b_frame_period", fs2 - fs1, 264);
    chk("b_vs_low_clks", vs_rise - vs_fall, 48);
    chk("b_hs_low_clks", bhs_rise - bhs_fall, 3);
    chk("b_seen_colour", {seen_c, seen_blk}, 2'b11);

    // ---- Unit B: reset inside vsync and hsync ----
    for (int i = 0; i < 300 && !(yb == 8 && xb == 20); i++) @(negedge clk);
    chk("b_mid_found", (yb == 8 && xb == 20), 1);
    chk("b_mid_pre_syncs", {hs_b, vs_b}, 2'b00);
    rst_b = 1'b1;
    #1;
    chk("b_mid_syncs", {hs_b, vs_b}, 2'b11);
    chk("b_mid_cnt", {xb, yb}, 0);
    chk("b_mid_blank_n", bn_b, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("b_mid_fs", fs_b, 1);
    @(negedge clk);
    chk("b_mid_adv", {xb, yb}, {10'd1, 10'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the pixel-coordinate interface that the overlay and highlight renderers consume.
- Generates the 640x480@60 VGA raster timing from the 50 MHz system clock.
- Drives x_cnt/y_cnt to the combinational renderers, then registers their returned RGB together with hsync, vsync and blank_n so all VGA DAC signals stay aligned.
- Sits between the board clock and the VGA DAC pins.

Parameters:
CLK_DIV, 2, system clocks per pixel; must be at least 1
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, hsync pulse width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
r_in  in  8  renderer red for the current x_cnt/y_cnt
g_in  in  8  renderer green
b_in  in  8  renderer blue
x_cnt  out  10  horizontal position, 0..H_TOTAL-1
y_cnt  out  10  vertical position, 0..V_TOTAL-1
active  out  1  1 when x_cnt < H_ACTIVE and y_cnt < V_ACTIVE
pix_tick  out  1  one-clk strobe per pixel; also drives the DAC clock enable
frame_start  out  1  one-clk pulse at the pix_tick where x_cnt=0 and y_cnt=0
vga_hs  out  1  hsync, active low, registered
vga_vs  out  1  vsync, active low, registered
vga_blank_n  out  1  registered copy of active
vga_r  out  8  registered red; forced 0 when not active
vga_g  out  8  registered green; forced 0 when not active
vga_b  out  8  registered blue; forced 0 when not active

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be 1024 or less.
- Clock divider: div_cnt counts 0..CLK_DIV-1 and wraps. pix_tick=1 for the one clk where div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_tick is held at 1.
- Horizontal counter h_cnt advances only on pix_tick and wraps from H_TOTAL-1 to 0.
- Vertical counter v_cnt advances on the pix_tick where h_cnt wraps, and wraps from V_TOTAL-1 to 0. Both counters wrap on the same tick at frame end.
- Line order: active region, then front porch, then sync, then back porch. Frame order is the same.
- x_cnt=h_cnt and y_cnt=v_cnt, driven directly from the counter registers. active is combinational from the counters. Renderers return r/g/b_in within the same clk.
- Output stage updates only on pix_tick, so latency is 1 pixel:
  - vga_hs = !(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC)
  - vga_vs = !(V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC)
  - vga_blank_n = active
  - vga_r/g/b = active ? r/g/b_in : 0
  - Result: the DAC sees the color for coordinate (x,y) on the same register edge as that pixel's sync and blank levels.
- frame_start is combinational: pix_tick & (h_cnt==0) & (v_cnt==0).
- Reset (asynchronous, on assert) forces:
  - div_cnt=0, h_cnt=0, v_cnt=0
  - vga_hs=1, vga_vs=1, vga_blank_n=0, vga_r/g/b=0
- After reset deasserts, the first pix_tick occurs CLK_DIV clks later and is a frame_start.
- Reset asserted mid-frame abandons the frame immediately; no partial sync pulse is held.
- r/g/b_in are ignored whenever active=0.

Test Plan:
- Reset release, CLK_DIV=2 -> pix_tick every 2nd clk; first frame_start 2 clks after release; outputs at reset values until the first tick.
- Free-run one line -> hs low for exactly 96 ticks (192 clks), starting at h_cnt=656 and ending at h_cnt=751; line period 800 ticks = 1600 clks.
- Free-run one frame -> vs low for 2 lines, starting at v_cnt=490; frame_start period 420000 ticks = 840000 clks; y_cnt wraps 524->0 on the same tick x_cnt wraps 799->0.
- Renderer stub returns r_in={x_cnt[7:0]}, g_in=y_cnt[7:0], b_in=8'hFF -> at the output edge for (639,479) vga_r=8'h7F, vga_g=8'hDF, blank_n=1; at (640,479) all colors 0, blank_n=0.
- Assert rst at h_cnt=700, v_cnt=491 (inside vsync) -> vga_vs=1 and vga_hs=1 asynchronously; counters 0; the next frame_start comes CLK_DIV clks after release.
- CLK_DIV=1 -> pix_tick constant 1; line = 800 clks; hs/colour alignment unchanged.
